// File: rtl/patch_loader_pkg.sv
// Shared definitions for the FM patch loader: patch geometry, FSM states and
// the positions of the packed operator-amplitude words inside a patch.
package patch_loader_pkg;

    // Words per patch: 48 envelope words (8 per operator) + 3 amplitude words.
    localparam int DEFAULT_NUM_WORDS = 51;

    // Each patch occupies a 64-word slot in the store; word index is 6 bits.
    localparam int WORD_AW = 6;

    // Offsets of the packed operator-amplitude words.
    localparam int AMP_WORD_OFS0 = 48;
    localparam int AMP_WORD_OFS1 = 49;
    localparam int AMP_WORD_OFS2 = 50;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        STREAM,
        FINISH
    } state_t;

endpackage

// File: rtl/patch_ram.sv
// Patch store: one write port, one synchronous read port with a 1-cycle
// latency. A read and a write to the same address in one cycle return the
// old contents. The array itself is never reset; only the read register is.
module patch_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk24,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_reg;

    // Host write port.
    always_ff @(posedge clk24) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is issued so the voice
    // data bus stays aligned with the last address presented.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/patch_loader.sv
// Streams one stored FM patch into a voice's write/addr/param port, one word
// per clock, then resolves the voice trigger.
// Build option: define PATCH_LOADER_AUTOTRIG_EN to retrigger the voice at the
// end of every load; otherwise only a pending note_on triggers it.
module patch_loader
    import patch_loader_pkg::*;
#(
    parameter int  NUM_WORDS   = DEFAULT_NUM_WORDS,
    parameter int  NUM_PATCHES = 8,
    localparam int PW          = $clog2(NUM_PATCHES)
) (
    input  logic          clk24,
    input  logic          rst,
    input  logic          host_we,
    input  logic [PW-1:0] host_patch,
    input  logic [5:0]    host_addr,
    input  logic [31:0]   host_data,
    input  logic          load_valid,
    input  logic [PW-1:0] load_patch,
    output logic          load_ready,
    input  logic          note_on,
    output logic          voice_write,
    output logic [5:0]    voice_addr,
    output logic [31:0]   voice_param,
    output logic          voice_trig,
    output logic          busy,
    output logic          done
);

`ifdef PATCH_LOADER_AUTOTRIG_EN
    localparam logic AUTOTRIG = 1'b1;
`else
    localparam logic AUTOTRIG = 1'b0;
`endif

    localparam logic [WORD_AW-1:0] NUM_WORDS_W = WORD_AW'(NUM_WORDS);
    localparam logic [WORD_AW-1:0] LAST_WORD   = WORD_AW'(NUM_WORDS - 1);

    state_t              state_reg, state_next;
    logic [WORD_AW-1:0]  word_cnt_reg, word_cnt_next;
    logic [PW-1:0]       patch_reg, patch_next;
    logic                pending_reg, pending_next;
    logic                load_ready_reg, load_ready_next;
    logic                voice_write_reg, voice_write_next;
    logic [WORD_AW-1:0]  voice_addr_reg, voice_addr_next;
    logic                voice_trig_reg, voice_trig_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                handshake;
    logic                host_wr_ok;
    logic                rd_en;
    logic [PW+WORD_AW-1:0] rd_addr;

    // load_ready is only ever high in IDLE, so this is the accept condition.
    assign handshake  = load_valid & load_ready_reg;
    // Words beyond the patch length are dropped rather than stored.
    assign host_wr_ok = host_we && (host_addr < NUM_WORDS_W);

    patch_ram #(
        .AW (PW + WORD_AW),
        .DW (32)
    ) u_ram (
        .clk24 (clk24),
        .rst   (rst),
        .we    (host_wr_ok),
        .waddr ({host_patch, host_addr}),
        .wdata (host_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (voice_param)
    );

    // Next-state, word sequencing, trigger resolution and registered outputs.
    // The read issued for word k in a given cycle is presented together with
    // voice_write/voice_addr=k on the following edge, so the RAM output
    // register doubles as the voice_param register.
    always_comb begin
        state_next       = state_reg;
        word_cnt_next    = word_cnt_reg;
        patch_next       = patch_reg;
        pending_next     = pending_reg;
        load_ready_next  = 1'b0;
        voice_write_next = 1'b0;
        voice_addr_next  = voice_addr_reg;
        voice_trig_next  = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        rd_en            = 1'b0;
        rd_addr          = {patch_reg, word_cnt_reg};

        unique case (state_reg)
            IDLE: begin
                load_ready_next = ~handshake;
                if (handshake) begin
                    state_next    = PREFETCH;
                    patch_next    = load_patch;
                    word_cnt_next = '0;
                    busy_next     = 1'b1;
                    // A note arriving with the handshake waits for FINISH.
                    pending_next  = note_on;
                end else if (note_on) begin
                    voice_trig_next = 1'b1;
                end
            end

            PREFETCH, STREAM: begin
                // PREFETCH is the word-0 read; STREAM covers words 1..last.
                rd_en            = 1'b1;
                voice_write_next = 1'b1;
                voice_addr_next  = word_cnt_reg;
                busy_next        = 1'b1;
                if (note_on) begin
                    pending_next = 1'b1;
                end
                if (word_cnt_reg == LAST_WORD) begin
                    state_next = FINISH;
                end else begin
                    state_next    = STREAM;
                    word_cnt_next = word_cnt_reg + 1'b1;
                end
            end

            FINISH: begin
                done_next       = 1'b1;
                // Pending, same-cycle and automatic triggers merge into one pulse.
                voice_trig_next = pending_reg | note_on | AUTOTRIG;
                pending_next    = 1'b0;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any stream in progress.
    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            word_cnt_reg    <= '0;
            patch_reg       <= '0;
            pending_reg     <= 1'b0;
            load_ready_reg  <= 1'b0;
            voice_write_reg <= 1'b0;
            voice_addr_reg  <= '0;
            voice_trig_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            word_cnt_reg    <= word_cnt_next;
            patch_reg       <= patch_next;
            pending_reg     <= pending_next;
            load_ready_reg  <= load_ready_next;
            voice_write_reg <= voice_write_next;
            voice_addr_reg  <= voice_addr_next;
            voice_trig_reg  <= voice_trig_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    assign load_ready  = load_ready_reg;
    assign voice_write = voice_write_reg;
    assign voice_addr  = voice_addr_reg;
    assign voice_trig  = voice_trig_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_patch_loader.sv
// Directed bench for patch_loader. Inputs change and outputs are sampled on
// the falling edge of clk24.
module tb_patch_loader;

`ifdef PATCH_LOADER_AUTOTRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk24 = 1'b0;
    logic        rst;
    logic        host_we;
    logic [2:0]  host_patch;
    logic [5:0]  host_addr;
    logic [31:0] host_data;
    logic        load_valid;
    logic [2:0]  load_patch;
    logic        load_ready;
    logic        note_on;
    logic        voice_write;
    logic [5:0]  voice_addr;
    logic [31:0] voice_param;
    logic        voice_trig;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [0:7][0:50];

    patch_loader dut (
        .clk24       (clk24),
        .rst         (rst),
        .host_we     (host_we),
        .host_patch  (host_patch),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .load_valid  (load_valid),
        .load_patch  (load_patch),
        .load_ready  (load_ready),
        .note_on     (note_on),
        .voice_write (voice_write),
        .voice_addr  (voice_addr),
        .voice_param (voice_param),
        .voice_trig  (voice_trig),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk24 = ~clk24;

    // Host write of one word; caller is at a falling edge, returns at the next.
    task automatic write_word(input int p, input int a, input logic [31:0] d);
        host_we    = 1'b1;
        host_patch = p[2:0];
        host_addr  = a[5:0];
        host_data  = d;
        @(negedge clk24);
        host_we = 1'b0;
        if (a < 51) model[p][a] = d;
    endtask

    // One load of patch p. Observation index i is cycle T+1+i for a handshake
    // at edge T. note_mask bit i pulses note_on at index i; note_hs pulses it
    // with the handshake; coll_k >= 0 rewrites word coll_k of p in the very
    // cycle its stream read is issued.
    task automatic do_load(input int p, input logic [63:0] note_mask, input bit note_hs,
                           input bit keep_valid, input int coll_k, input logic [31:0] coll_d);
        bit exp_trig;
        exp_trig = AUTO || note_hs || (note_mask != 64'd0);
        vectors++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_load p=%0d got %b want 1", p, load_ready);
        end
        load_valid = 1'b1;
        load_patch = p[2:0];
        note_on    = note_hs;
        for (int i = 0; i <= 53; i++) begin
            @(negedge clk24);
            note_on = 1'b0;
            host_we = 1'b0;
            vectors++;
            if (busy !== (i <= 51)) begin
                errors++;
                $display("FAIL busy i=%0d got %b want %b", i, busy, (i <= 51));
            end
            vectors++;
            if (voice_write !== (i >= 1 && i <= 51)) begin
                errors++;
                $display("FAIL voice_write i=%0d got %b want %b", i, voice_write, (i >= 1 && i <= 51));
            end
            if (i >= 1 && i <= 51) begin
                vectors++;
                if (voice_addr !== 6'(i - 1)) begin
                    errors++;
                    $display("FAIL voice_addr i=%0d got %0d want %0d", i, voice_addr, i - 1);
                end
                vectors++;
                if (voice_param !== model[p][i-1]) begin
                    errors++;
                    $display("FAIL voice_param i=%0d got %h want %h", i, voice_param, model[p][i-1]);
                end
            end
            vectors++;
            if (done !== (i == 52)) begin
                errors++;
                $display("FAIL done i=%0d got %b want %b", i, done, (i == 52));
            end
            vectors++;
            if (load_ready !== (i == 53)) begin
                errors++;
                $display("FAIL load_ready i=%0d got %b want %b", i, load_ready, (i == 53));
            end
            vectors++;
            if (voice_trig !== (i == 52 && exp_trig)) begin
                errors++;
                $display("FAIL voice_trig i=%0d got %b want %b", i, voice_trig, (i == 52 && exp_trig));
            end
            if (i == 0 && !keep_valid) load_valid = 1'b0;
            if (note_mask[i]) note_on = 1'b1;
            if (i == coll_k) begin
                host_we    = 1'b1;
                host_patch = p[2:0];
                host_addr  = coll_k[5:0];
                host_data  = coll_d;
            end
        end
        if (coll_k >= 0) model[p][coll_k] = coll_d;
        $display("load patch %0d notes=%h hs_note=%0d coll=%0d checked", p, note_mask, note_hs, coll_k);
    endtask

    task automatic test_reset();
        rst = 1'b1; host_we = 1'b0; host_patch = '0; host_addr = '0; host_data = '0;
        load_valid = 1'b0; load_patch = '0; note_on = 1'b0;
        repeat (3) @(negedge clk24);
        vectors++;
        if ({load_ready, voice_write, voice_addr, voice_param, voice_trig, busy, done} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%b/%h/%h/%b/%b/%b want all 0", load_ready, voice_write,
                     voice_addr, voice_param, voice_trig, busy, done);
        end
        rst = 1'b0;
        @(negedge clk24);
        vectors++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", load_ready);
        end
        $display("reset checked");
    endtask

    task automatic test_fill();
        for (int k = 0; k < 51; k++) write_word(3, k, 32'hA500_0000 + k);
        for (int k = 0; k < 51; k++) write_word(0, k, 32'h0C00_0000 + k);
        write_word(0, 55, 32'hDEAD_BEEF);
        $display("patches 3 and 0 written");
    endtask

    task automatic test_idle_note();
        note_on = 1'b1;
        @(negedge clk24);
        note_on = 1'b0;
        vectors++;
        if (voice_trig !== 1'b1) begin
            errors++;
            $display("FAIL idle_trig got %b want 1", voice_trig);
        end
        @(negedge clk24);
        vectors++;
        if (voice_trig !== 1'b0) begin
            errors++;
            $display("FAIL idle_trig_clear got %b want 0", voice_trig);
        end
        $display("idle note_on checked");
    endtask

    task automatic test_reset_midstream();
        load_valid = 1'b1;
        load_patch = 3'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk24);
            load_valid = 1'b0;
            note_on = (i == 5);
        end
        note_on = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({voice_write, busy, load_ready, done, voice_trig, voice_addr, voice_param} !== 42'd0) begin
            errors++;
            $display("FAIL midstream_reset got wr=%b busy=%b rdy=%b done=%b trig=%b a=%h d=%h want all 0",
                     voice_write, busy, load_ready, done, voice_trig, voice_addr, voice_param);
        end
        @(negedge clk24);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk24);
            vectors++;
            if ({load_ready, voice_write, done, voice_trig} !== 4'b1000) begin
                errors++;
                $display("FAIL after_reset i=%0d got rdy=%b wr=%b done=%b trig=%b want 1000", i,
                         load_ready, voice_write, done, voice_trig);
            end
        end
        $display("midstream reset checked");
        do_load(3, 64'd0, 1'b0, 1'b0, -1, 32'd0);
    endtask

    initial begin
        test_reset();
        test_fill();
        do_load(3, 64'd0, 1'b0, 1'b0, -1, 32'd0);                          // plain stream / autotrig
        do_load(0, 64'd0, 1'b0, 1'b0, -1, 32'd0);                          // addr 55 never appears
        test_idle_note();
        do_load(3, (64'd1 << 5) | (64'd1 << 20) | (64'd1 << 40), 1'b0, 1'b0, -1, 32'd0);
        do_load(0, 64'd1 << 51, 1'b0, 1'b0, -1, 32'd0);                    // note_on during FINISH
        do_load(0, 64'd0, 1'b1, 1'b0, -1, 32'd0);                          // note_on with handshake
        do_load(3, 64'd0, 1'b0, 1'b1, -1, 32'd0);                          // back-to-back, valid held
        do_load(0, 64'd0, 1'b0, 1'b0, 10, 32'h5A5A_0010);                  // collision: old data
        do_load(0, 64'd0, 1'b0, 1'b0, -1, 32'd0);                          // new data next load
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/patch_loader.md
# patch_loader

Sequencer that programs a six-operator FM voice from an on-chip patch store. A host fills up to NUM_PATCHES patches of NUM_WORDS 32-bit words. On a load request the block streams one patch into the voice's write/addr/param port, one word per clock, then fires the voice trigger. It sits between the host/MIDI control logic and one `voice` instance, and is the only driver of that voice's write, addr, param and trig inputs.

## Interface
- NUM_WORDS, 51: words per patch. Words 0..47 are envelope params, 8 per operator; words 48..50 are packed operator amplitudes.
- NUM_PATCHES, 8: patches held; must be a power of two.
- PW, $clog2(NUM_PATCHES): patch index width.

Ports:
- clk24  in  1  sole clock; every register is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- host_we  in  1  patch-store write strobe.
- host_patch  in  PW  patch index for the host write.
- host_addr  in  6  word index for the host write; writes with host_addr >= NUM_WORDS are ignored.
- host_data  in  32  word to store.
- load_valid  in  1  load request.
- load_patch  in  PW  patch to load; sampled on handshake.
- load_ready  out  1  high only in IDLE.
- note_on  in  1  single-cycle trigger request.
- voice_write  out  1  write strobe to the voice.
- voice_addr  out  6  voice parameter address.
- voice_param  out  32  voice parameter data.
- voice_trig  out  1  single-cycle trigger to the voice.
- busy  out  1  high from the handshake through the last write.
- done  out  1  single-cycle pulse when a load completes.

## Operation
- Handshake: a load is accepted when load_valid and load_ready are both high on a clock edge. load_patch is latched at that edge. While load_ready is low, load_valid may be held high; the request is simply not accepted.
- FSM states:
  - IDLE: load_ready=1. On handshake go to PREFETCH.
  - PREFETCH: issue the RAM read for word 0, then go to STREAM.
  - STREAM: present word k with voice_write=1 and voice_addr=k. Issue the read for k+1. After k = NUM_WORDS-1 go to FINISH.
  - FINISH: done=1 and the trigger is resolved (rules below). Return to IDLE.
- Patch store: NUM_PATCHES x 64 words, synchronous read with 1-cycle latency. If a host write and a stream read hit the same address in the same cycle, the read returns the old data. Host writes are accepted in every state, including to the patch being streamed.
- note_on in IDLE: voice_trig pulses on the next cycle.
- note_on while busy: sets a pending flag. Repeated note_on pulses collapse into one. The pending trigger is issued in FINISH and the flag is cleared.
- note_on in the same cycle as a handshake counts as "while busy".
- note_on in FINISH: voice_trig pulses in FINISH; the request is not issued twice.
- All outputs are registered. Reset values: load_ready=0 while rst is asserted and 1 from the first edge after release; voice_write=0, voice_addr=0, voice_param=0, voice_trig=0, busy=0, done=0.
- Reset mid-stream: the FSM goes to IDLE immediately and the pending flag is cleared. The voice keeps any partially written parameters. Patch-store contents are not reset.

## Timing
- Handshake at edge T:
  - PREFETCH in cycle T+1.
  - voice_write high in cycles T+2..T+52, with voice_addr 0..50.
  - FINISH, done and trigger in cycle T+53.
  - load_ready high again at T+54.
- busy is high in cycles T+1..T+52.
- Back-to-back loads: minimum spacing is 54 cycles between accepted handshakes.
- voice_param always equals the stored word addressed by voice_addr. A host write to that word lands from the next load.

## Configuration
- PATCH_LOADER_AUTOTRIG_EN defined: FINISH always pulses voice_trig, so every load retriggers the voice. A pending note_on is merged into that same single pulse.
- Not defined: FINISH pulses voice_trig only if note_on is pending; otherwise the load is silent.

## Structure
- Package patch_loader_pkg holds:
  - the NUM_WORDS default (51);
  - the FSM state enum (IDLE, PREFETCH, STREAM, FINISH);
  - the amplitude word offsets (48, 49, 50).
- Sub-module patch_ram: one write port and one synchronous read port, depth NUM_PATCHES*64 x 32.
- The FSM, word counter and pending-trigger flag live in patch_loader.

## Test plan
- Host writes patch 3, word k = 32'hA5000000+k, for k = 0..50. Load patch 3 at T: 51 writes in T+2..T+52, addr k carrying A5000000+k. done at T+53. load_ready returns at T+54.
- Host write to patch 0, addr 55 (>= NUM_WORDS). Load patch 0: word 55 is never written and never appears on the voice port.
- Idle note_on at cycle N -> voice_trig at N+1 only. Three note_on pulses during a load -> exactly one voice_trig, at T+53.
- With PATCH_LOADER_AUTOTRIG_EN and no note_on: voice_trig at T+53. Without the macro: no voice_trig.
- Assert rst at T+20 mid-stream: voice_write is 0 immediately and busy=0. After release, load_ready=1 and no trig or done occurs. A reload streams the full patch from word 0.
- During a stream, the host rewrites the current word's address in the same cycle the read is issued: the old value is streamed, and the next load streams the new value.
